// File: rtl/arbitro_mux_3in_pkg.sv
// Shared definitions for the 3-requester round-robin mux arbiter:
// select codes, FSM encoding, requester indices and arbitration helpers.
package arbitro_mux_3in_pkg;

    localparam logic [1:0] SEL_A = 2'd2;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd0;

    localparam int IDX_A   = 0;
    localparam int IDX_B   = 1;
    localparam int IDX_C   = 2;
    localparam int NUM_REQ = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // One-hot winner scanning ptr, ptr+1, ptr+2 (mod 3); zero when nobody requests.
    // Walking downwards lets the nearest requester overwrite farther ones.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
        logic [2:0] pos;
        rr_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (req[pos[1:0]]) rr_pick = 3'b001 << pos;
        end
    endfunction

    function automatic logic [1:0] gnt_to_sel(input logic [2:0] gnt);
        if (gnt[IDX_A])      gnt_to_sel = SEL_A;
        else if (gnt[IDX_B]) gnt_to_sel = SEL_B;
        else                 gnt_to_sel = SEL_C;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [2:0] gnt);
        if (gnt[IDX_A])      next_ptr = 2'(IDX_B);
        else if (gnt[IDX_B]) next_ptr = 2'(IDX_C);
        else                 next_ptr = 2'(IDX_A);
    endfunction

endpackage

// File: rtl/arbitro_mux_3in_mux.sv
// 3-to-1 data multiplexor steered by the arbiter's select code.
module Multiplexor_3in_1out
    import arbitro_mux_3in_pkg::*;
#(
    parameter int DB = 16
) (
    input  logic [1:0]    sel_i,
    input  logic [DB-1:0] dato_a_i,
    input  logic [DB-1:0] dato_b_i,
    input  logic [DB-1:0] dato_c_i,
    output logic [DB-1:0] dato_o
);

    always_comb begin
        case (sel_i)
            SEL_A:   dato_o = dato_a_i;
            SEL_B:   dato_o = dato_b_i;
            SEL_C:   dato_o = dato_c_i;
            default: dato_o = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_mux_3in.sv
// Round-robin arbiter for a shared 3-to-1 mux: grants one requester at a time,
// moves up to BURST words into a registered valid/ready output stage.
module arbitro_mux_3in
    import arbitro_mux_3in_pkg::*;
#(
    parameter int DB    = 16,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          req_c,
    input  logic [DB-1:0] dato_a,
    input  logic [DB-1:0] dato_b,
    input  logic [DB-1:0] dato_c,
    output logic          ack_a,
    output logic          ack_b,
    output logic          ack_c,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          gnt_c,
    output logic [1:0]    sel,
    output logic [DB-1:0] salida,
    output logic          salida_valid,
    input  logic          salida_ready
);

    localparam logic [2:0] BURST_CNT = 3'(BURST);

    state_e        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DB-1:0] salida_q, salida_d;
    logic          valid_q, valid_d;

    logic [2:0]    req_v;
    logic [2:0]    pick;
    logic [DB-1:0] mux_dato;
    logic          gnt_req, beat, last_beat;

    assign req_v     = {req_c, req_b, req_a};
    assign pick      = rr_pick(ptr_q, req_v);
    assign gnt_req   = |(gnt_q & req_v);
    assign beat      = (state_q == GRANT) && gnt_req && (!valid_q || salida_ready);
    assign last_beat = beat && ((cnt_q + 3'd1) == BURST_CNT);

    Multiplexor_3in_1out #(.DB(DB)) u_mux (
        .sel_i    (sel_q),
        .dato_a_i (dato_a),
        .dato_b_i (dato_b),
        .dato_c_i (dato_c),
        .dato_o   (mux_dato)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    gnt_d   = pick;
                    sel_d   = gnt_to_sel(pick);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (beat) cnt_d = cnt_q + 3'd1;
                // A dropped req ends the grant rather than stalling it.
                if (last_beat || !gnt_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = next_ptr(gnt_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            salida_d = mux_dato;
            valid_d  = 1'b1;
        end else if (salida_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= SEL_A;
            ptr_q    <= 2'(IDX_A);
            cnt_q    <= '0;
            salida_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
            valid_q  <= valid_d;
        end
    end

    // Acks are suppressed while reset is asserted so an in-flight word is dropped cleanly.
    assign ack_a        = beat && gnt_q[IDX_A] && !reset;
    assign ack_b        = beat && gnt_q[IDX_B] && !reset;
    assign ack_c        = beat && gnt_q[IDX_C] && !reset;
    assign gnt_a        = gnt_q[IDX_A];
    assign gnt_b        = gnt_q[IDX_B];
    assign gnt_c        = gnt_q[IDX_C];
    assign sel          = sel_q;
    assign salida       = salida_q;
    assign salida_valid = valid_q;

endmodule

// File: tb/tb_arbitro_mux_3in.sv
// Bench for arbitro_mux_3in: reference table, directed corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_arbitro_mux_3in;

    localparam int DB    = 16;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, req_b, req_c;
    logic [DB-1:0] dato_a, dato_b, dato_c;
    logic          ack_a, ack_b, ack_c;
    logic          gnt_a, gnt_b, gnt_c;
    logic [1:0]    sel;
    logic [DB-1:0] salida;
    logic          salida_valid;
    logic          salida_ready;

    int n_vec = 0;
    int n_err = 0;

    arbitro_mux_3in #(.DB(DB), .BURST(BURST)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .dato_a       (dato_a),
        .dato_b       (dato_b),
        .dato_c       (dato_c),
        .ack_a        (ack_a),
        .ack_b        (ack_b),
        .ack_c        (ack_c),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .gnt_c        (gnt_c),
        .sel          (sel),
        .salida       (salida),
        .salida_valid (salida_valid),
        .salida_ready (salida_ready)
    );

    always #5 clk = ~clk;

    // Model: owner -1 means nobody holds the bus; requesters 0=A, 1=B, 2=C.
    int            m_own, m_ptr, m_beats, m_sel;
    logic [DB-1:0] m_out;
    logic          m_valid;

    // Observations and trackers collected every cycle.
    logic [2:0]    obs_gnt, obs_ack, prev_gnt;
    logic [1:0]    obs_sel;
    logic          obs_vld;
    logic [DB-1:0] obs_sal;
    int            ack_cnt [3];
    int            order [$];
    logic [DB-1:0] acked [$];
    logic [DB-1:0] consumed [$];

    typedef struct {
        logic          rst;
        logic [2:0]    req;
        logic          rdy;
        logic [2:0]    gnt;
        logic [1:0]    sel;
        logic [2:0]    ack;
        logic          vld;
        logic [DB-1:0] sal;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_beats = 0; m_sel = 2; m_out = '0; m_valid = 1'b0;
    endtask

    task automatic clear_track();
        for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
        order.delete(); acked.delete(); consumed.delete();
        prev_gnt = '0;
    endtask

    task automatic set_req(input logic [2:0] r);
        {req_c, req_b, req_a} = r;
    endtask

    // One clock: compare at negedge against the model, then advance the model at posedge.
    task automatic cycle();
        logic [2:0]    r, e_gnt, e_ack;
        logic [DB-1:0] d [3];
        logic          b;
        int            pick;
        @(negedge clk);
        r = {req_c, req_b, req_a};
        d[0] = dato_a; d[1] = dato_b; d[2] = dato_c;
        b = !reset && (m_own >= 0) && r[m_own] && (!m_valid || salida_ready);
        e_gnt = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        e_ack = b ? e_gnt : 3'b000;
        obs_gnt = {gnt_c, gnt_b, gnt_a};
        obs_ack = {ack_c, ack_b, ack_a};
        obs_sel = sel; obs_vld = salida_valid; obs_sal = salida;
        check("model {gnt,sel,ack,vld,salida}",
              64'({obs_gnt, obs_sel, obs_ack, obs_vld, obs_sal}),
              64'({e_gnt, 2'(m_sel), e_ack, m_valid, m_out}));
        for (int i = 0; i < 3; i++) if (obs_ack[i]) begin ack_cnt[i]++; acked.push_back(d[i]); end
        if (obs_vld && salida_ready) consumed.push_back(obs_sal);
        if (obs_gnt != 3'b000 && prev_gnt == 3'b000) order.push_back(obs_gnt[0] ? 0 : obs_gnt[1] ? 1 : 2);
        prev_gnt = obs_gnt;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (b) begin m_out = d[m_own]; m_valid = 1'b1; m_beats++; end
            else if (salida_ready) m_valid = 1'b0;
            if (m_own < 0) begin
                pick = -1;
                for (int k = 0; k < 3; k++) if (pick < 0 && r[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
                if (pick >= 0) begin m_own = pick; m_sel = 2 - pick; end
            end else if ((b && m_beats == BURST) || !r[m_own]) begin
                m_ptr = (m_own + 1) % 3; m_own = -1; m_beats = 0;
            end
        end
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            dato_a = DB'($urandom); dato_b = DB'($urandom); dato_c = DB'($urandom);
            cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; set_req(3'b000); salida_ready = 1'b1;
        cycle();
        reset = 1'b0;
        clear_track();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 3'b000, 1'b1, 3'b000, 2'd2, 3'b000, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 3'b001, 1'b1, 3'b000, 2'd2, 3'b000, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd2, 3'b001, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd2, 3'b001, 1'b1, 16'h00A1};
        tbl[4] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd2, 3'b001, 1'b1, 16'h00A1};
        tbl[5] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd2, 3'b001, 1'b1, 16'h00A1};
        tbl[6] = '{1'b0, 3'b001, 1'b1, 3'b000, 2'd2, 3'b000, 1'b1, 16'h00A1};
        tbl[7] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd2, 3'b001, 1'b0, 16'h00A1};
        tbl[8] = '{1'b0, 3'b000, 1'b1, 3'b001, 2'd2, 3'b000, 1'b1, 16'h00A1};
        tbl[9] = '{1'b0, 3'b000, 1'b1, 3'b000, 2'd2, 3'b000, 1'b0, 16'h00A1};

        reset = 1'b1; set_req(3'b000); salida_ready = 1'b1;
        dato_a = 16'h00A1; dato_b = 16'h00B1; dato_c = 16'h00C1;
        @(posedge clk); #1;
        model_reset();
        clear_track();

        // Single A burst from reset.
        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst; set_req(tbl[i].req); salida_ready = tbl[i].rdy;
            cycle();
            check($sformatf("table row %0d", i),
                  64'({obs_gnt, obs_sel, obs_ack, obs_vld, obs_sal}),
                  64'({tbl[i].gnt, tbl[i].sel, tbl[i].ack, tbl[i].vld, tbl[i].sal}));
        end

        // All three requesting continuously: A, B, C, A with one bubble each.
        do_reset();
        set_req(3'b111);
        step(20);
        check("rr order size>=4", 64'(order.size() >= 4), 64'(1));
        if (order.size() >= 4) begin
            check("rr order[0]", 64'(order[0]), 64'(0));
            check("rr order[1]", 64'(order[1]), 64'(1));
            check("rr order[2]", 64'(order[2]), 64'(2));
            check("rr order[3]", 64'(order[3]), 64'(0));
        end
        check("rr acks A", 64'(ack_cnt[0]), 64'(8));
        check("rr acks B", 64'(ack_cnt[1]), 64'(4));
        check("rr acks C", 64'(ack_cnt[2]), 64'(4));

        // B drops req after 2 beats; pointer moves to C.
        do_reset();
        set_req(3'b010);
        step(3);
        set_req(3'b101);
        step(3);
        check("early release acks B", 64'(ack_cnt[1]), 64'(2));
        check("early release acks A", 64'(ack_cnt[0]), 64'(0));
        check("next after B", 64'(obs_gnt), 64'(3'b100));

        // C stalled by the sink for 5 cycles after its first beat.
        do_reset();
        set_req(3'b100);
        step(2);
        salida_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall holds salida", 64'({obs_vld, obs_sal}), 64'({1'b1, acked[0]}));
            check("stall acks C", 64'(ack_cnt[2]), 64'(1));
        end
        salida_ready = 1'b1;
        step(3);
        check("stall resume acks C", 64'(ack_cnt[2]), 64'(4));
        step(1);
        check("stall release gnt", 64'(obs_gnt), 64'(0));

        // Reset at beat 2 of A.
        do_reset();
        set_req(3'b001);
        step(2);
        reset = 1'b1;
        step(1);
        check("reset drops ack", 64'(obs_ack), 64'(0));
        reset = 1'b0;
        set_req(3'b011);
        step(1);
        check("post reset outputs", 64'({obs_gnt, obs_sel, obs_ack, obs_vld, obs_sal}),
              64'({3'b000, 2'd2, 3'b000, 1'b0, 16'h0000}));
        step(1);
        check("post reset first grant", 64'(obs_gnt), 64'(3'b001));

        // C alone with ready toggling: every acked word consumed exactly once.
        do_reset();
        set_req(3'b100);
        for (int i = 0; i < 30 && ack_cnt[2] < 4; i++) begin
            salida_ready = i[0] ? 1'b0 : 1'b1;
            dato_c = 16'hC000 + 16'(i);
            cycle();
        end
        set_req(3'b000);
        salida_ready = 1'b1;
        step(2);
        check("toggle acks C", 64'(ack_cnt[2]), 64'(4));
        check("toggle consumed count", 64'(consumed.size()), 64'(4));
        if (consumed.size() == 4 && acked.size() == 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("toggle word %0d", i), 64'(consumed[i]), 64'(acked[i]));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            req_a = ($urandom_range(0, 3) != 0);
            req_b = ($urandom_range(0, 3) != 0);
            req_c = ($urandom_range(0, 3) != 0);
            salida_ready = ($urandom_range(0, 9) < 7);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
